// File: rtl/stack_sequencer.sv
// Stack-unit program sequencer: steps a small program memory, one instruction per two cycles.
// Optional STACK_SEQ_CLR_EN macro adds a CLEAR state that pulses s_rst before each run.
module stack_sequencer #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [W+3:0]  prog_data,
  input  logic          start,
  input  logic          abort,
  output logic [W-1:0]  s_in,
  output logic [3:0]    s_op,
  output logic          s_apply,
  output logic          s_rst,
  input  logic [W-1:0]  s_head,
  input  logic          s_empty,
  input  logic          s_valid,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] err_pc,
  output logic [W-1:0]  result
);

  // state   | meaning
  // S_IDLE  | no run yet or aborted; program memory writable
  // S_CLEAR | one-cycle stack-unit clear before the first issue (macro only)
  // S_ISSUE | present mem[pc] to the stack unit, or finish on HALT
  // S_WAIT  | sample s_valid for the instruction just applied
  // S_DONE  | run finished, result captured
  // S_ERROR | stack unit reported a fault at err_pc
  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERROR
`ifdef STACK_SEQ_CLR_EN
    , S_CLEAR
`endif
  } state_t;

`ifdef STACK_SEQ_CLR_EN
  localparam state_t RUN_ENTRY = S_CLEAR;
`else
  localparam state_t RUN_ENTRY = S_ISSUE;
`endif

  localparam logic [AW-1:0] LAST_PC = AW'(DEPTH - 1);
  localparam logic [3:0]    OP_HALT = 4'hF;

  state_t         state;
  logic [W+3:0]   mem [DEPTH];
  logic [W+3:0]   cur;
  logic [3:0]     cur_op;
  logic [W-1:0]   cur_arg;
  logic           prog_open;
  logic           unused_ok;

  assign unused_ok = s_empty;

  assign cur       = mem[pc];
  assign cur_op    = cur[W+3:W];
  assign cur_arg   = cur[W-1:0];
  assign prog_open = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);

  // Memory is deliberately left out of reset so a program survives rst.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && prog_open) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      err_pc <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
    end else if (abort) begin
      state <= S_IDLE;
      pc    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      error <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            state <= RUN_ENTRY;
            pc    <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
          end
        end
`ifdef STACK_SEQ_CLR_EN
        S_CLEAR: state <= S_ISSUE;
`endif
        S_ISSUE: begin
          if (cur_op == OP_HALT) begin
            state  <= S_DONE;
            result <= s_head;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!s_valid) begin
            state  <= S_ERROR;
            err_pc <= pc;
            error  <= 1'b1;
            busy   <= 1'b0;
          end else if (pc == LAST_PC) begin
            state  <= S_DONE;
            result <= s_head;
            done   <= 1'b1;
            busy   <= 1'b0;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_ISSUE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Issue strobe is decoded from registered state and the registered program word.
  always_comb begin
    s_apply = 1'b0;
    s_op    = '0;
    s_in    = '0;
    if (state == S_ISSUE && cur_op != OP_HALT) begin
      s_apply = 1'b1;
      s_op    = cur_op;
      s_in    = cur_arg;
    end
  end

`ifdef STACK_SEQ_CLR_EN
  assign s_rst = (state == S_CLEAR);
`else
  assign s_rst = 1'b0;
`endif

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer with a small behavioural stack unit (push=0, divide=8).
// Honours STACK_SEQ_CLR_EN for the expected run-start latency.
module tb_stack_sequencer;

`ifdef STACK_SEQ_CLR_EN
  localparam int CLR = 1;
`else
  localparam int CLR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = '0;
  logic [11:0] prog_data = '0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  s_in;
  logic [3:0]  s_op;
  logic        s_apply;
  logic        s_rst;
  logic [7:0]  s_head;
  logic        s_empty;
  logic        s_valid;
  logic        busy, done, error;
  logic [3:0]  pc, err_pc;
  logic [7:0]  result;

  stack_sequencer #(.W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .abort(abort),
    .s_in(s_in), .s_op(s_op), .s_apply(s_apply), .s_rst(s_rst),
    .s_head(s_head), .s_empty(s_empty), .s_valid(s_valid),
    .busy(busy), .done(done), .error(error), .pc(pc), .err_pc(err_pc),
    .result(result)
  );

  always #5 clk = ~clk;

  // Behavioural stack unit
  logic [7:0] stk [32];
  int         sp = 0;
  logic       m_valid = 1'b1;

  assign s_head  = (sp > 0) ? stk[sp-1] : 8'd0;
  assign s_empty = (sp == 0);
  assign s_valid = m_valid;

  always @(posedge clk) begin
    if (rst || s_rst) begin
      sp      <= 0;
      m_valid <= 1'b1;
    end else if (s_apply) begin
      case (s_op)
        4'h0: if (sp < 32) begin
                stk[sp] <= s_in;
                sp      <= sp + 1;
                m_valid <= 1'b1;
              end else m_valid <= 1'b0;
        4'h8: if (sp >= 2 && stk[sp-1] != 8'd0) begin
                stk[sp-2] <= stk[sp-2] / stk[sp-1];
                sp        <= sp - 1;
                m_valid   <= 1'b1;
              end else m_valid <= 1'b0;
        default: m_valid <= 1'b0;
      endcase
    end
  end

  // Activity monitor
  int cyc = 0, start_cyc = 0, first_ap = 0, last_ap = 0;
  int apply_cnt = 0, gap_bad = 0, srst_cnt = 0, srst_cyc = 0;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (start) start_cyc = cyc;
    if (s_rst) begin
      srst_cnt = srst_cnt + 1;
      srst_cyc = cyc;
    end
    if (s_apply) begin
      if (apply_cnt == 0) first_ap = cyc;
      else if (cyc - last_ap != 2) gap_bad = gap_bad + 1;
      last_ap   = cyc;
      apply_cnt = apply_cnt + 1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr_stats();
    apply_cnt = 0;
    gap_bad   = 0;
    srst_cnt  = 0;
  endtask

  task automatic prog(input int a, input logic [3:0] op, input logic [7:0] v);
    prog_we   = 1'b1;
    prog_addr = 4'(a);
    prog_data = {op, v};
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n = 0;
    while (!(done || error) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done | error), 1);
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_err_pc", 32'(err_pc), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_s_apply", 32'(s_apply), 0);
    chk("rst_s_rst", 32'(s_rst), 0);
    chk("rst_s_bus", 32'({s_op, s_in}), 0);
    rst = 1'b0;

    // Write during rst is ignored; memory keeps the HALT
    prog(0, 4'hF, 8'h00);
    rst = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = {4'h0, 8'h55}; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; prog_we = 1'b0; start = 1'b0;
    chk("rst_ovr_busy", 32'(busy), 0);
    chk("rst_ovr_apply", 32'(s_apply), 0);
    clr_stats();
    pulse_start();
    wait_end("halt_end", 20);
    chk("halt_applies", 32'(apply_cnt), 0);
    chk("halt_done", 32'(done), 1);
    chk("halt_result", 32'(result), 0);

    // 10 / 2 = 5
    prog(0, 4'h0, 8'd10);
    prog(1, 4'h0, 8'd2);
    prog(2, 4'h8, 8'd0);
    prog(3, 4'hF, 8'd0);
    clr_stats();
    pulse_start();
    chk("run_busy", 32'(busy), 1);
    chk("run_s_rst_now", 32'(s_rst), 32'(CLR));
    wait_end("div_end", 40);
    chk("div_applies", 32'(apply_cnt), 3);
    chk("div_first_lat", 32'(first_ap - start_cyc), 32'(1 + CLR));
    chk("div_gap", 32'(gap_bad), 0);
    chk("div_done", 32'(done), 1);
    chk("div_error", 32'(error), 0);
    chk("div_busy", 32'(busy), 0);
    chk("div_result", 32'(result), 5);
    chk("div_srst_cnt", 32'(srst_cnt), 32'(CLR));
`ifdef STACK_SEQ_CLR_EN
    chk("div_srst_lat", 32'(srst_cyc - start_cyc), 1);
`endif

    // Divide by zero faults at pc 2
    prog(1, 4'h0, 8'd0);
    clr_stats();
    pulse_start();
    wait_end("dz_end", 40);
    repeat (4) @(negedge clk);
    chk("dz_error", 32'(error), 1);
    chk("dz_err_pc", 32'(err_pc), 2);
    chk("dz_pc", 32'(pc), 2);
    chk("dz_done", 32'(done), 0);
    chk("dz_applies", 32'(apply_cnt), 3);
    chk("dz_result_kept", 32'(result), 5);

    // 16 pushes, no HALT: ends at pc 15
    for (int i = 0; i < 16; i++) prog(i, 4'h0, 8'(i + 1));
    clr_stats();
    pulse_start();
    wait_end("full_end", 80);
    chk("full_applies", 32'(apply_cnt), 16);
    chk("full_gap", 32'(gap_bad), 0);
    chk("full_done", 32'(done), 1);
    chk("full_error", 32'(error), 0);
    chk("full_pc", 32'(pc), 15);
    chk("full_result", 32'(result), 16);

    // Abort in WAIT of instruction 1 with a concurrent write
    prog(0, 4'h0, 8'd1);
    prog(1, 4'h0, 8'd2);
    prog(2, 4'hF, 8'd0);
    clr_stats();
    pulse_start();
    begin
      int n = 0;
      while (apply_cnt < 2 && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("ab_reach_wait", 32'(apply_cnt), 2);
    abort = 1'b1; prog_we = 1'b1; prog_addr = 4'd2; prog_data = {4'h0, 8'h33};
    @(negedge clk);
    abort = 1'b0; prog_we = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_error", 32'(error), 0);
    chk("ab_pc", 32'(pc), 0);
    chk("ab_apply", 32'(s_apply), 0);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk);
    chk("sa_busy", 32'(busy), 0);
    chk("sa_applies", 32'(apply_cnt), 2);
    clr_stats();
    pulse_start();
    wait_end("ab_rerun_end", 40);
    chk("ab_rerun_applies", 32'(apply_cnt), 2);
    chk("ab_rerun_result", 32'(result), 2);

    // Write and start together: run sees the new word
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = {4'hF, 8'h00}; start = 1'b1;
    clr_stats();
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_end("ws_end", 40);
    chk("ws_applies", 32'(apply_cnt), 1);
    chk("ws_result", 32'(result), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
STACK_SEQUENCER -- requirements
Module: stack_sequencer

Interface
REQ-001 Parameter W, default 8: data width of operand and stack head.
REQ-002 Parameter DEPTH, default 16: program memory entries; AW = clog2(DEPTH).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 prog_we  in  1  program write strobe.
REQ-006 prog_addr  in  AW  program write address.
REQ-007 prog_data  in  4+W  instruction {op[3:0], operand[W-1:0]}.
REQ-008 start  in  1  run request, one-cycle pulse.
REQ-009 abort  in  1  cancel run, one-cycle pulse.
REQ-010 s_in  out  W  operand to stack unit.
REQ-011 s_op  out  4  opcode to stack unit.
REQ-012 s_apply  out  1  one-cycle execute strobe to stack unit.
REQ-013 s_rst  out  1  stack-unit clear pulse.
REQ-014 s_head, s_empty, s_valid  in  W, 1, 1  stack-unit status.
REQ-015 busy, done, error  out  1 each  run status.
REQ-016 pc  out  AW  current instruction index; err_pc  out  AW  index of the faulting instruction.
REQ-017 result  out  W  s_head captured at program completion.

Function
REQ-018 States: IDLE, CLEAR (only with macro), ISSUE, WAIT, DONE, ERROR.
REQ-019 Program memory: DEPTH x (4+W) registers, written only in IDLE, DONE or ERROR; prog_we ignored while busy.
REQ-020 IDLE/DONE/ERROR + start -> pc=0, done=0, error=0, next state ISSUE (or CLEAR); busy=1 from next cycle.
REQ-021 prog_we and start in the same cycle: write is committed; run uses the new contents.
REQ-022 ISSUE: read mem[pc] combinationally; op==4'hF is HALT -> DONE, no s_apply.
REQ-023 ISSUE, op!=4'hF: s_apply=1, s_op=op, s_in=operand for exactly that cycle -> WAIT.
REQ-024 s_apply=0, s_op=0, s_in=0 in every state other than ISSUE.
REQ-025 WAIT: sample s_valid; 0 -> ERROR with err_pc=pc; 1 and pc==DEPTH-1 -> DONE; 1 otherwise -> pc+1, ISSUE.
REQ-026 Throughput: 2 cycles per instruction; pc never wraps.
REQ-027 DONE entry: result<=s_head, done=1, busy=0; held until next start or rst.
REQ-028 ERROR entry: error=1, busy=0; result unchanged; held until next start or rst.
REQ-029 abort in any state -> IDLE next cycle; busy=0, done=0, error=0, pc=0; no s_apply in that next cycle.
REQ-030 abort and start in the same cycle: abort wins.
REQ-031 s_empty does not affect sequencing; stack-unit faults are reported only via s_valid.

Reset
REQ-032 rst overrides all inputs: state=IDLE, pc=0, err_pc=0, result=0, busy=done=error=0, s_apply=s_rst=0, s_in=s_op=0.
REQ-033 Program memory is not cleared by rst.
REQ-034 rst during ISSUE/WAIT aborts the run; s_apply is 0 the cycle after rst is asserted.

Configuration
REQ-035 Macro STACK_SEQ_CLR_EN defined: start -> CLEAR state, s_rst=1 for exactly one cycle, then ISSUE at pc=0; first s_apply is 2 cycles after start.
REQ-036 Macro STACK_SEQ_CLR_EN undefined: no CLEAR state, s_rst tied 0; first s_apply is 1 cycle after start.

Verification
REQ-037 rst pulse with prog_we active -> all outputs 0; memory write ignored during rst; mem retains prior contents.
REQ-038 Program {0,10},{0,2},{8,0},{F,0}, start, bench stack model -> three s_apply pulses 2 cycles apart, done=1, result=5, error=0.
REQ-039 Program {0,10},{0,0},{8,0},{F,0}, model returns s_valid=0 on divide -> error=1, err_pc=2, done=0, no further s_apply.
REQ-040 16 pushes of 1..16, no HALT -> exactly 16 s_apply pulses, done after WAIT at pc=15, pc not wrapped.
REQ-041 abort in the WAIT of instruction 1, with prog_we in the same cycle -> IDLE next cycle, pc=0, write dropped; start+abort same cycle -> stays IDLE.
REQ-042 STACK_SEQ_CLR_EN defined -> s_rst high exactly the cycle after start; first s_apply one cycle later; undefined -> s_rst constant 0.
